// File: rtl/fp_mul_pkg.sv
// fp_mul_pkg: shared definitions for the sequential binary32 multiplier.
//   state_t     : controller states (IDLE, UNPACK, MULT, NORM, ROUND)
//   BIAS/EXP_W/MAN_W : binary32 field geometry
//   QNAN/PINF   : canonical quiet NaN and positive infinity encodings
package fp_mul_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UNPACK = 3'd1,
        MULT   = 3'd2,
        NORM   = 3'd3,
        ROUND  = 3'd4
    } state_t;

    localparam int          BIAS  = 127;
    localparam int          EXP_W = 8;
    localparam int          MAN_W = 23;
    localparam logic [31:0] QNAN  = 32'h7FC0_0000;
    localparam logic [31:0] PINF  = 32'h7F80_0000;

endpackage

// File: rtl/fp_mul_shiftadd.sv
// fp_mul_shiftadd: 24x24 unsigned sequential shift-add multiplier.
// Ports:
//   clk, rst   : clock, synchronous active-low reset (clears the step counter)
//   load       : capture mcand_in / mplier_in and clear the accumulator
//   step       : consume one multiplier bit (LSB first)
//   mcand_in   : 24-bit multiplicand
//   mplier_in  : 24-bit multiplier
//   p          : 48-bit accumulated product
//   done       : high during the 24th step (count == 23 while stepping)
module fp_mul_shiftadd
    import fp_mul_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [MAN_W:0] mcand_in,
    input  logic [MAN_W:0] mplier_in,
    output logic [2*MAN_W+1:0] p,
    output logic        done
);

    logic [4:0]           count;
    logic [2*MAN_W+1:0]   mcand;
    logic [MAN_W:0]       mplier;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= 5'd0;
        end else if (load) begin
            count <= 5'd0;
        end else if (step) begin
            count <= count + 5'd1;
        end
    end

    // Multiplicand walks left while the multiplier walks right, so bit i of
    // the multiplier always meets the multiplicand shifted by i.
    always_ff @(posedge clk) begin
        if (load) begin
            mcand  <= {{(MAN_W+1){1'b0}}, mcand_in};
            mplier <= mplier_in;
            p      <= '0;
        end else if (step) begin
            if (mplier[0]) begin
                p <= p + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    assign done = step && (count == 5'd23);

endmodule

// File: rtl/fp_mul_core.sv
// fp_mul_core: sequential IEEE-754 binary32 multiplier, fixed 27-cycle latency.
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous active-low reset, aborts any operation
//   startFP   : one-cycle start pulse, honoured only while idle
//   Abus/Bbus : operands, captured on the accepted start edge
//   resultBus : registered product, held until the next result
//   doneFP    : high = idle and result valid, low = busy
//   ovf/unf/inv : overflow / underflow / invalid flags for the last result
// Build option: FPMUL_RNE_EN selects round-to-nearest-even; without it the
// product is truncated (round toward zero) and guard/sticky are not built.
module fp_mul_core
    import fp_mul_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        startFP,
    input  logic [31:0] Abus,
    input  logic [31:0] Bbus,
    output logic [31:0] resultBus,
    output logic        doneFP,
    output logic        ovf,
    output logic        unf,
    output logic        inv
);

    state_t state;

    logic [31:0]         a_lat, b_lat;
    logic                sign_r;
    logic signed [9:0]   exp_r;
    logic                spec_r;
    logic                spec_inv_r;
    logic [31:0]         spec_res_r;
    logic [MAN_W-1:0]    mant_r;
`ifdef FPMUL_RNE_EN
    logic                guard_r;
    logic                sticky_r;
`endif

    logic [2*MAN_W+1:0]  p;
    logic                sa_done;
    logic                sa_load, sa_step;

    logic [EXP_W-1:0]    a_exp, b_exp;
    logic [MAN_W-1:0]    a_frac, b_frac;
    logic                a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [MAN_W:0]      a_man, b_man;
    logic                sign_c;
    logic signed [9:0]   exp_sum;
    logic                spec_c, spec_inv_c;
    logic [31:0]         spec_res_c;

    logic [MAN_W:0]      rnd;
    logic signed [9:0]   exp_rnd;
    logic [MAN_W-1:0]    mant_fin;
    logic [33:0]         packed_res;

`ifdef FPMUL_RNE_EN
    function automatic logic [MAN_W:0] round_mant(input logic [MAN_W-1:0] m,
                                                  input logic g,
                                                  input logic s);
        return {1'b0, m} + {{MAN_W{1'b0}}, g & (s | m[0])};
    endfunction
`else
    function automatic logic [MAN_W:0] round_mant(input logic [MAN_W-1:0] m);
        return {1'b0, m};
    endfunction
`endif

    // Saturating pack: returns {ovf, unf, word}.
    function automatic logic [33:0] pack_result(input logic s,
                                                input logic signed [9:0] e,
                                                input logic [MAN_W-1:0] m);
        if (e >= 10'sd255) begin
            return {2'b10, s, PINF[30:0]};
        end else if (e <= 10'sd0) begin
            return {2'b01, s, 31'd0};
        end else begin
            return {2'b00, s, e[EXP_W-1:0], m};
        end
    endfunction

    // Operand decode from the latched copies; subnormals count as zero.
    always_comb begin
        a_exp   = a_lat[30:23];
        b_exp   = b_lat[30:23];
        a_frac  = a_lat[22:0];
        b_frac  = b_lat[22:0];
        a_zero  = (a_exp == 8'd0);
        b_zero  = (b_exp == 8'd0);
        a_inf   = (a_exp == 8'hFF) && (a_frac == '0);
        b_inf   = (b_exp == 8'hFF) && (b_frac == '0);
        a_nan   = (a_exp == 8'hFF) && (a_frac != '0);
        b_nan   = (b_exp == 8'hFF) && (b_frac != '0);
        a_man   = a_zero ? '0 : {1'b1, a_frac};
        b_man   = b_zero ? '0 : {1'b1, b_frac};
        sign_c  = a_lat[31] ^ b_lat[31];
        exp_sum = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp})
                  - $signed(10'(BIAS));

        spec_c     = 1'b1;
        spec_inv_c = 1'b0;
        spec_res_c = '0;
        if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) begin
            spec_res_c = QNAN;
            spec_inv_c = 1'b1;
        end else if (a_inf || b_inf) begin
            spec_res_c = {sign_c, PINF[30:0]};
        end else if (a_zero || b_zero) begin
            spec_res_c = {sign_c, 31'd0};
        end else begin
            spec_c = 1'b0;
        end
    end

    assign sa_load = (state == UNPACK);
    assign sa_step = (state == MULT);

    fp_mul_shiftadd u_shiftadd (
        .clk       (clk),
        .rst       (rst),
        .load      (sa_load),
        .step      (sa_step),
        .mcand_in  (a_man),
        .mplier_in (b_man),
        .p         (p),
        .done      (sa_done)
    );

`ifndef FPMUL_RNE_EN
    // Bits below the kept mantissa do not matter when truncating.
    logic unused_low_bits;
    assign unused_low_bits = ^p[22:0];
`endif

    always_comb begin
`ifdef FPMUL_RNE_EN
        rnd = round_mant(mant_r, guard_r, sticky_r);
`else
        rnd = round_mant(mant_r);
`endif
        // Mantissa carry-out: 1.111..1 rounds up to 10.000..0.
        exp_rnd    = exp_r + $signed({9'd0, rnd[MAN_W]});
        mant_fin   = rnd[MAN_W] ? '0 : rnd[MAN_W-1:0];
        packed_res = pack_result(sign_r, exp_rnd, mant_fin);
    end

    // Control and outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            resultBus <= '0;
            doneFP    <= 1'b1;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            inv       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (startFP) begin
                        state  <= UNPACK;
                        doneFP <= 1'b0;
                    end
                end
                UNPACK: state <= MULT;
                MULT: begin
                    if (sa_done) begin
                        state <= NORM;
                    end
                end
                NORM:  state <= ROUND;
                ROUND: begin
                    state  <= IDLE;
                    doneFP <= 1'b1;
                    if (spec_r) begin
                        resultBus <= spec_res_r;
                        inv       <= spec_inv_r;
                        ovf       <= 1'b0;
                        unf       <= 1'b0;
                    end else begin
                        resultBus <= packed_res[31:0];
                        ovf       <= packed_res[33];
                        unf       <= packed_res[32];
                        inv       <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (state == IDLE && startFP) begin
            a_lat <= Abus;
            b_lat <= Bbus;
        end
        if (state == UNPACK) begin
            sign_r     <= sign_c;
            exp_r      <= exp_sum;
            spec_r     <= spec_c;
            spec_inv_r <= spec_inv_c;
            spec_res_r <= spec_res_c;
        end
        if (state == NORM) begin
            if (p[47]) begin
                mant_r   <= p[46:24];
                exp_r    <= exp_r + 10'sd1;
`ifdef FPMUL_RNE_EN
                guard_r  <= p[23];
                sticky_r <= |p[22:0];
`endif
            end else begin
                mant_r   <= p[45:23];
`ifdef FPMUL_RNE_EN
                guard_r  <= p[22];
                sticky_r <= |p[21:0];
`endif
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_core.sv
module tb_fp_mul_core;

    logic        clk;
    logic        rst;
    logic        startFP;
    logic [31:0] Abus, Bbus;
    logic [31:0] resultBus;
    logic        doneFP, ovf, unf, inv;

    int checks = 0;
    int errors = 0;

    fp_mul_core dut (
        .clk       (clk),
        .rst       (rst),
        .startFP   (startFP),
        .Abus      (Abus),
        .Bbus      (Bbus),
        .resultBus (resultBus),
        .doneFP    (doneFP),
        .ovf       (ovf),
        .unf       (unf),
        .inv       (inv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference: exact integer product of the significands, then the
    // normalize / round / saturate rules applied arithmetically.
    // Returns {inv, ovf, unf, result}.
    function automatic logic [34:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          ea, eb, e, sh;
        logic [63:0] fa, fb, prod, m;
        bit          za, zb, ia, ib, na, nb;
`ifdef FPMUL_RNE_EN
        logic [63:0] rem, half;
`endif
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = {41'd0, a[22:0]};
        fb = {41'd0, b[22:0]};
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (fa == 0);
        ib = (eb == 255) && (fb == 0);
        na = (ea == 255) && (fa != 0);
        nb = (eb == 255) && (fb != 0);
        if (na || nb || (za && ib) || (ia && zb)) return {3'b100, 32'h7FC00000};
        if (ia || ib) return {3'b000, s, 31'h7F800000};
        if (za || zb) return {3'b000, s, 31'd0};
        prod = (fa + 64'h800000) * (fb + 64'h800000);
        e = ea + eb - 127;
        if (prod >= (64'd1 << 47)) begin
            sh = 24;
            e  = e + 1;
        end else begin
            sh = 23;
        end
        m = prod >> sh;
`ifdef FPMUL_RNE_EN
        rem  = prod - (m << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && m[0])) m = m + 1;
`endif
        if (m == 64'h1000000) begin
            m = 64'h800000;
            e = e + 1;
        end
        if (e >= 255) return {3'b010, s, 31'h7F800000};
        if (e <= 0)   return {3'b001, s, 31'd0};
        return {3'b000, s, 8'(e), m[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0]  e;
        logic [22:0] f;
        logic        s;
        s = 1'($urandom_range(0, 1));
        f = 23'($urandom);
        case ($urandom_range(0, 9))
            0: begin e = 8'd0;   f = 23'd0; end
            1: begin e = 8'hFF;  f = 23'd0; end
            2: begin e = 8'hFF;  f = f | 23'd1; end
            3:       e = 8'd0;
            4:       e = 8'($urandom_range(200, 254));
            5:       e = 8'($urandom_range(1, 60));
            6:       f = 23'h7FFFFF | 23'($urandom_range(0, 1));
            default: e = 8'($urandom_range(1, 254));
        endcase
        if ($urandom_range(0, 9) == 6) e = 8'($urandom_range(100, 154));
        return {s, e, f};
    endfunction

    // One operation from an idle DUT; optional extra start pulse at cycle pulse_cyc.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int pulse_cyc);
        logic [34:0] exp_v;
        logic [31:0] prev;
        bit          busy_ok;
        exp_v = ref_mul(a, b);
        prev  = resultBus;
        Abus = a;
        Bbus = b;
        startFP = 1'b1;
        @(posedge clk); #1;
        startFP = 1'b0;
        Abus = $urandom;
        Bbus = $urandom;
        busy_ok = (doneFP === 1'b0) && (resultBus === prev);
        for (int c = 1; c <= 26; c++) begin
            if (c == pulse_cyc) startFP = 1'b1;
            @(posedge clk); #1;
            startFP = 1'b0;
            if (doneFP !== 1'b0 || resultBus !== prev) busy_ok = 0;
        end
        chk("busy", {31'd0, busy_ok}, 32'd1);
        @(posedge clk); #1;
        chk("done", {31'd0, doneFP}, 32'd1);
        chk("result", resultBus, exp_v[31:0]);
        chk("flags", {29'd0, inv, ovf, unf}, {29'd0, exp_v[34:32]});
    endtask

    logic [31:0] dir_a [6];
    logic [31:0] dir_b [6];
    logic [31:0] dir_r [6];
    logic [2:0]  dir_f [6];

    initial begin
        logic [31:0] held;
        bit          idle_ok;

        dir_a[0] = 32'h3FC00000; dir_b[0] = 32'h40000000; dir_r[0] = 32'h40400000; dir_f[0] = 3'b000;
        dir_a[1] = 32'h3FC00001; dir_b[1] = 32'h3FC00001;
`ifdef FPMUL_RNE_EN
        dir_r[1] = 32'h40100002;
`else
        dir_r[1] = 32'h40100001;
`endif
        dir_f[1] = 3'b000;
        dir_a[2] = 32'h00000000; dir_b[2] = 32'h7F800000; dir_r[2] = 32'h7FC00000; dir_f[2] = 3'b100;
        dir_a[3] = 32'h7F800000; dir_b[3] = 32'hBF800000; dir_r[3] = 32'hFF800000; dir_f[3] = 3'b000;
        dir_a[4] = 32'h7F000000; dir_b[4] = 32'h7F000000; dir_r[4] = 32'h7F800000; dir_f[4] = 3'b010;
        dir_a[5] = 32'h00800000; dir_b[5] = 32'h00800000; dir_r[5] = 32'h00000000; dir_f[5] = 3'b001;

        rst = 1'b0;
        startFP = 1'b0;
        Abus = 32'd0;
        Bbus = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", resultBus, 32'd0);
        chk("rst_done", {31'd0, doneFP}, 32'd1);
        chk("rst_flags", {29'd0, inv, ovf, unf}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            run_op(dir_a[i], dir_b[i], 0);
            chk("dir_result", resultBus, dir_r[i]);
            chk("dir_flags", {29'd0, inv, ovf, unf}, {29'd0, dir_f[i]});
        end

        // Second start during the operation must be ignored.
        run_op(32'h40400000, 32'hC0A00000, 10);
        held = resultBus;
        idle_ok = 1;
        repeat (30) begin
            @(posedge clk); #1;
            if (doneFP !== 1'b1 || resultBus !== held) idle_ok = 0;
        end
        chk("ignored_start", {31'd0, idle_ok}, 32'd1);

        // Reset in the middle of MULT aborts the operation.
        Abus = 32'h3F800001;
        Bbus = 32'h3F800001;
        startFP = 1'b1;
        @(posedge clk); #1;
        startFP = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_done", {31'd0, doneFP}, 32'd1);
        chk("abort_result", resultBus, 32'd0);
        chk("abort_flags", {29'd0, inv, ovf, unf}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        run_op(32'h3FC00000, 32'h40000000, 0);

        for (int i = 0; i < 250; i++) begin
            run_op(rand_op(), rand_op(), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
